// File: rtl/clk_div_cfg_ctrl.sv
// clk_div_cfg_ctrl
// Upstream controller for a clock divider. It owns the divider ratio and enable,
// and applies ratio changes or shutdowns only at divided-period boundaries. The
// divider is gated off for a fixed number of reference cycles around each change.
// A mirror counter tracks the divider phase so that boundaries can be seen here.

module clk_div_cfg_ctrl #(
    parameter int RATIO_WIDTH = 4,
    parameter int GATE_CYCLES = 2,   // legal range 1..15
    parameter int RST_RATIO   = 1
) (
    input  logic                   i_ref_clk,
    input  logic                   i_rst,
    input  logic                   i_sys_en,
    input  logic                   i_cfg_wr,
    input  logic [RATIO_WIDTH-1:0] i_cfg_ratio,
    output logic [RATIO_WIDTH-1:0] o_div_ratio,
    output logic                   o_clk_en,
    output logic                   o_cfg_busy,
    output logic                   o_cfg_ack,
    output logic                   o_cfg_err
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_ON    = 2'd1,
        ST_DRAIN = 2'd2,
        ST_GATE  = 2'd3
    } state_t;

    localparam logic [RATIO_WIDTH-1:0] RST_R     = RATIO_WIDTH'(RST_RATIO);
    localparam logic [RATIO_WIDTH-1:0] ONE_R     = RATIO_WIDTH'(1);
    localparam logic [RATIO_WIDTH-1:0] TWO_R     = RATIO_WIDTH'(2);
    localparam logic [RATIO_WIDTH-1:0] ALL_ONES  = {RATIO_WIDTH{1'b1}};
    localparam logic [3:0]             GATE_LOAD = 4'(GATE_CYCLES - 1);

    // Registered state
    state_t                   r_state;
    logic [RATIO_WIDTH-1:0]   r_div_ratio;
    logic                     r_clk_en;
    logic                     r_cfg_ack;
    logic                     r_cfg_err;
    logic [RATIO_WIDTH-1:0]   r_cnt;
    logic [3:0]               r_gate_cnt;
    logic [RATIO_WIDTH-1:0]   r_pend_ratio;
    logic                     r_pend_cfg;
    logic                     r_pend_off;
    logic                     r_err_hold;

    // Next-state values
    state_t                   w_state_nxt;
    logic [RATIO_WIDTH-1:0]   w_ratio_nxt;
    logic [RATIO_WIDTH-1:0]   w_pend_ratio_nxt;
    logic                     w_pend_cfg_nxt;
    logic                     w_pend_off_nxt;
    logic [3:0]               w_gate_cnt_nxt;
    logic                     w_ack_nxt;
    logic                     w_err_req;
    logic                     w_err_nxt;
    logic                     w_err_hold_nxt;

    // Derived conditions
    logic [RATIO_WIDTH-1:0]   w_ratio_m1;
    logic                     w_bypass;
    logic                     w_boundary;
    logic                     w_busy;

    assign w_ratio_m1 = r_div_ratio - ONE_R;
    // Ratios 0 and 1 pass the reference clock straight through: no period to protect.
    assign w_bypass   = (r_div_ratio < TWO_R);
    assign w_boundary = (r_clk_en && (r_cnt == w_ratio_m1)) || w_bypass;
    assign w_busy     = (r_state == ST_DRAIN) || (r_state == ST_GATE);

    // FSM state register
    always_ff @(posedge i_ref_clk or negedge i_rst) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (!i_rst) begin
            r_state <= ST_OFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, pending-request and ratio selection
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        w_state_nxt      = r_state;
        w_ratio_nxt      = r_div_ratio;
        w_pend_ratio_nxt = r_pend_ratio;
        w_pend_cfg_nxt   = r_pend_cfg;
        w_pend_off_nxt   = r_pend_off;
        w_gate_cnt_nxt   = r_gate_cnt;
        w_ack_nxt        = 1'b0;

        unique case (r_state)
            ST_OFF: begin
                // Divider is stopped, so a write can be applied immediately.
                if (i_cfg_wr) begin
                    w_ratio_nxt = i_cfg_ratio;
                    w_ack_nxt   = 1'b1;
                end
                if (i_sys_en) begin
                    w_state_nxt = ST_ON;
                end
            end

            ST_ON: begin
                if (i_cfg_wr || !i_sys_en) begin
                    w_pend_cfg_nxt = i_cfg_wr;
                    w_pend_off_nxt = !i_sys_en;
                    if (i_cfg_wr) begin
                        w_pend_ratio_nxt = i_cfg_ratio;
                    end
                    if (w_bypass) begin
                        // Every cycle is a boundary: gate on the very next edge.
                        w_state_nxt    = ST_GATE;
                        w_gate_cnt_nxt = GATE_LOAD;
                        if (i_cfg_wr) begin
                            w_ratio_nxt = i_cfg_ratio;
                        end
                    end else begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                if (!i_sys_en) begin
                    w_pend_off_nxt = 1'b1;
                end
                if (w_boundary) begin
                    w_state_nxt    = ST_GATE;
                    w_gate_cnt_nxt = GATE_LOAD;
                    if (r_pend_cfg) begin
                        w_ratio_nxt = r_pend_ratio;
                    end
                end
            end

            ST_GATE: begin
                if (r_gate_cnt == 4'd0) begin
                    w_state_nxt    = (r_pend_off || !i_sys_en) ? ST_OFF : ST_ON;
                    w_ack_nxt      = r_pend_cfg;
                    w_pend_cfg_nxt = 1'b0;
                    w_pend_off_nxt = 1'b0;
                end else begin
                    w_gate_cnt_nxt = r_gate_cnt - 4'd1;
                end
            end

            default: begin
                w_state_nxt = ST_OFF;
            end
        endcase
    end

    // A rejected write whose error would collide with an ack is deferred one cycle
    // so ack and err are never asserted together.
    always_comb begin
        w_err_req      = i_cfg_wr && w_busy;
        w_err_nxt      = (w_err_req || r_err_hold) && !w_ack_nxt;
        w_err_hold_nxt = (w_err_req || r_err_hold) && w_ack_nxt;
    end

    // Datapath and output registers
    always_ff @(posedge i_ref_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_div_ratio  <= RST_R;
            r_clk_en     <= 1'b0;
            r_cfg_ack    <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_gate_cnt   <= 4'd0;
            r_pend_ratio <= RST_R;
            r_pend_cfg   <= 1'b0;
            r_pend_off   <= 1'b0;
            r_err_hold   <= 1'b0;
        end else begin
            r_div_ratio  <= w_ratio_nxt;
            r_clk_en     <= (w_state_nxt == ST_ON) || (w_state_nxt == ST_DRAIN);
            r_cfg_ack    <= w_ack_nxt;
            r_cfg_err    <= w_err_nxt;
            r_gate_cnt   <= w_gate_cnt_nxt;
            r_pend_ratio <= w_pend_ratio_nxt;
            r_pend_cfg   <= w_pend_cfg_nxt;
            r_pend_off   <= w_pend_off_nxt;
            r_err_hold   <= w_err_hold_nxt;
        end
    end

    // Mirror counter following the divider's phase
    always_ff @(posedge i_ref_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cnt <= ALL_ONES;
        end else if (r_clk_en) begin
            r_cnt <= (r_cnt == w_ratio_m1) ? '0 : r_cnt + ONE_R;
        end else begin
            r_cnt <= ALL_ONES;
        end
    end

    assign o_div_ratio = r_div_ratio;
    assign o_clk_en    = r_clk_en;
    assign o_cfg_busy  = w_busy;
    assign o_cfg_ack   = r_cfg_ack;
    assign o_cfg_err   = r_cfg_err;

endmodule

// File: doc/clk_div_cfg_ctrl.md
CLK_DIV_CFG_CTRL -- requirements
Module: clk_div_cfg_ctrl

Upstream controller for the clock divider. It drives divider ratio and enable, and changes them only at divided-period boundaries.

Interface
REQ-001 SHALL have parameter RATIO_WIDTH, default 4: width of ratio ports and mirror counter.
REQ-002 SHALL have parameter GATE_CYCLES, default 2: number of i_ref_clk cycles o_clk_en is held low during an update (legal range 1..15).
REQ-003 SHALL have parameter RST_RATIO, default 1: o_div_ratio value after reset.
REQ-004 SHALL have port i_ref_clk, input, 1: reference clock; all logic is on the rising edge.
REQ-005 SHALL have port i_rst, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port i_sys_en, input, 1: level request to run the divided clock.
REQ-007 SHALL have port i_cfg_wr, input, 1: single-cycle ratio write strobe.
REQ-008 SHALL have port i_cfg_ratio, input, RATIO_WIDTH: requested ratio, sampled when i_cfg_wr=1.
REQ-009 SHALL have port o_div_ratio, output, RATIO_WIDTH: registered ratio to the divider.
REQ-010 SHALL have port o_clk_en, output, 1: registered enable to the divider.
REQ-011 SHALL have port o_cfg_busy, output, 1: high when state is DRAIN or GATE.
REQ-012 SHALL have port o_cfg_ack, output, 1: one-cycle pulse when a ratio write has taken effect.
REQ-013 SHALL have port o_cfg_err, output, 1: one-cycle pulse when a write is rejected.

Function
REQ-014 SHALL keep a mirror counter matching the divider:
- Reset value: all-ones.
- When o_clk_en=1: goes to 0 if count == o_div_ratio-1 (RATIO_WIDTH modulo arithmetic), else count+1.
- When o_clk_en=0: all-ones.
REQ-015 SHALL define boundary = (o_clk_en=1 and mirror count == o_div_ratio-1) or o_div_ratio < 2 (bypass ratios 0/1 have no period to protect).
REQ-016 SHALL implement the FSM states OFF, ON, DRAIN and GATE, with o_clk_en=1 exactly in ON and DRAIN.
REQ-017 SHALL, in OFF:
- Go to ON on the next edge when i_sys_en=1.
- On i_cfg_wr, load o_div_ratio=i_cfg_ratio on the next edge and pulse o_cfg_ack on that same edge.
- If i_sys_en=1 and i_cfg_wr=1 together, load the ratio and go to ON on the same edge.
REQ-018 SHALL, in ON:
- On i_cfg_wr, latch pend_ratio=i_cfg_ratio, set pend_cfg and go to DRAIN.
- On i_sys_en=0, set pend_off and go to DRAIN.
- If both occur in the same cycle, set both flags and go to DRAIN once.
REQ-019 SHALL, in DRAIN, go to GATE on the edge following the first cycle where boundary is true; o_clk_en falls on that edge.
REQ-020 SHALL, on GATE entry, load o_div_ratio=pend_ratio when pend_cfg=1, then hold GATE for exactly GATE_CYCLES cycles.
REQ-021 SHALL, on GATE exit:
- Go to OFF if pend_off=1 or i_sys_en=0; otherwise go to ON.
- Pulse o_cfg_ack on the exit edge when pend_cfg=1.
- Clear both pending flags.
REQ-022 SHALL reject i_cfg_wr while o_cfg_busy=1: pulse o_cfg_err on the next edge and leave pend_ratio unchanged.
REQ-023 SHALL register i_sys_en=0 seen in DRAIN as pend_off, with no extra delay.
REQ-024 SHALL, for i_sys_en rising in GATE, follow REQ-021 using the level at exit.
REQ-025 SHALL never assert o_cfg_ack and o_cfg_err in the same cycle.
REQ-026 SHALL keep o_clk_en low for at least GATE_CYCLES consecutive cycles around any ratio change made while running.

Reset
REQ-027 SHALL set the following while i_rst=0, independent of clock:
- state=OFF
- o_clk_en=0
- o_div_ratio=RST_RATIO
- mirror count=all-ones
- pend_cfg=0, pend_off=0, pend_ratio=RST_RATIO
- o_cfg_ack=0, o_cfg_err=0
REQ-028 SHALL abort an update in progress when reset is asserted mid-DRAIN or mid-GATE: no ack is issued and the old pending ratio is discarded.
REQ-029 SHALL make the first state change after reset deassertion on the first i_ref_clk rising edge.

Verification
REQ-030 Reset then OFF write: reset, i_cfg_wr with ratio=6 -> o_div_ratio=6 and o_cfg_ack on the next edge; o_clk_en stays 0.
REQ-031 Ratio change while running: ratio=4, i_sys_en=1, i_cfg_wr with ratio=7 at mirror count=0 -> o_clk_en falls at the edge after count=3; o_div_ratio=7 at GATE entry; o_clk_en=0 for 2 cycles, then 1; o_cfg_ack on the rise edge.
REQ-032 Rejected write: i_cfg_wr with ratio=5 during DRAIN -> o_cfg_err pulse; the final ratio is the first request.
REQ-033 Simultaneous write and disable: running at ratio=3, i_cfg_wr with ratio=8 and i_sys_en falling in the same cycle -> one drain; ends in OFF with o_div_ratio=8 and one o_cfg_ack.
REQ-034 Bypass ratio: running at ratio=1, i_cfg_wr with ratio=2 -> o_clk_en falls on the next edge, with no wait for a boundary.
REQ-035 Reset mid-GATE: assert i_rst during the GATE state -> outputs at reset values immediately; no o_cfg_ack.
